// File: rtl/dm_if.sv
// dm_if: load/store request/response bundle between the MEM stage and the
// data-memory responder.
//   req_valid/req_write/req_addr/req_size/req_signed/req_wdata : request (held while stall=1)
//   stall       : responder busy, pipeline must hold
//   resp_valid  : one-cycle response pulse
//   resp_rdata  : extended load data (0 for stores and errors)
//   resp_err    : misaligned access or illegal size
// master = MEM stage side, slave = responder side.
interface dm_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    input  stall, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    output stall, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the MEM-stage load/store port.
// Accepts one request at a time, accesses an internal 2^ADDR_WIDTH x 32-bit
// word array LATENCY cycles after accept, and returns sign/zero-extended load
// data. Stall is raised while a request is outstanding.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-high; clears FSM, outputs and memory
//   bus   : dm_if.slave request/response bundle
module dm_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input logic clk,
  input logic reset,
  dm_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'((LATENCY > 2) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  write_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [31:0]           mem_q [Depth];

  logic                  accept;
  logic                  commit;
  logic                  cur_write;
  logic [ADDR_WIDTH+1:0] cur_addr;
  logic [1:0]            cur_size;
  logic                  cur_signed;
  logic [31:0]           cur_wdata;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [4:0]            shamt;
  logic                  acc_err;
  logic [31:0]           rd_word;
  logic [31:0]           rd_shift;
  logic [31:0]           load_val;
  logic [31:0]           wmask;
  logic [31:0]           new_word;
  logic                  unused_addr;

  // Address bits above the word index are ignored: accesses wrap modulo depth.
  assign unused_addr = ^bus.req_addr[31:ADDR_WIDTH+2];

  // State register plus request latch, response registers and memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        write_q  <= bus.req_write;
        addr_q   <= bus.req_addr[ADDR_WIDTH+1:0];
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        wdata_q  <= bus.req_wdata;
      end
      if (commit && cur_write && !acc_err) begin
        mem_q[word_idx] <= new_word;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Access datapath. With LATENCY==1 the access happens on the accept edge,
  // before the latch is loaded, so the live request is used while in idle.
  always_comb begin
    accept     = (state_q == StIdle) && bus.req_valid;
    commit     = (state_d == StResp) && (state_q != StResp);
    cur_write  = (state_q == StIdle) ? bus.req_write : write_q;
    cur_addr   = (state_q == StIdle) ? bus.req_addr[ADDR_WIDTH+1:0] : addr_q;
    cur_size   = (state_q == StIdle) ? bus.req_size : size_q;
    cur_signed = (state_q == StIdle) ? bus.req_signed : signed_q;
    cur_wdata  = (state_q == StIdle) ? bus.req_wdata : wdata_q;

    word_idx = cur_addr[ADDR_WIDTH+1:2];
    shamt    = {cur_addr[1:0], 3'b000};
    acc_err  = (cur_size == 2'b11) ||
               ((cur_size == 2'b01) && cur_addr[0]) ||
               ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));

    rd_word  = mem_q[word_idx];
    rd_shift = rd_word >> shamt;
    unique case (cur_size)
      2'b00:   load_val = {{24{cur_signed & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = {{16{cur_signed & rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_shift;  // word: shamt is 0 for any non-error access
    endcase

    unique case (cur_size)
      2'b00:   wmask = 32'h0000_00FF << shamt;
      2'b01:   wmask = 32'h0000_FFFF << shamt;
      default: wmask = 32'hFFFF_FFFF;
    endcase
    new_word = (rd_word & ~wmask) | ((cur_wdata << shamt) & wmask);

    rdata_d = (commit && !cur_write && !acc_err) ? load_val : 32'h0;
    err_d   = commit && acc_err;
  end

  // Outputs.
  always_comb begin
    bus.stall      = !reset && (accept || (state_q == StWait));
    bus.resp_valid = (state_q == StResp);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  dm_if bus ();
  dm_if bus1 ();

  dm_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dm_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Scoreboard monitors: pop on every response pulse.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding, expected 0");
      end else begin
        e0 = q0.pop_front();
        check({e0.name, " rdata"}, bus.resp_rdata, e0.rdata);
        check({e0.name, " err"}, {31'b0, bus.resp_err}, {31'b0, e0.err});
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.resp_valid === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp1: resp_valid=1 with nothing outstanding, expected 0");
      end else begin
        e1 = q1.pop_front();
        check({e1.name, " rdata"}, bus1.resp_rdata, e1.rdata);
        check({e1.name, " err"}, {31'b0, bus1.resp_err}, {31'b0, e1.err});
      end
    end
  end

  // Issue one request (called at a negedge with the DUT idle) and follow it
  // through stall, response pulse and the return to idle.
  task automatic do_req(input bit which, input string name, input bit wr,
                        input logic [31:0] addr, input logic [1:0] size, input bit sgn,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input bit exp_err);
    exp_t e;
    int   n;
    int   lat;
    e.name  = name;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    lat = which ? 1 : 2;
    if (!which) begin
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
      bus.req_size = size; bus.req_signed = sgn; bus.req_wdata = wdata;
      q0.push_back(e);
    end else begin
      bus1.req_valid = 1'b1; bus1.req_write = wr; bus1.req_addr = addr;
      bus1.req_size = size; bus1.req_signed = sgn; bus1.req_wdata = wdata;
      q1.push_back(e);
    end
    n = 0;
    #1;
    while ((which ? bus1.stall : bus.stall) === 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " stall_cycles"}, n, lat);
    check({name, " resp_valid"}, {31'b0, which ? bus1.resp_valid : bus.resp_valid}, 32'd1);
    bus.req_valid  = 1'b0;
    bus1.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({name, " pulse_end"}, {31'b0, which ? bus1.resp_valid : bus.resp_valid}, 32'd0);
    check({name, " rdata_clear"}, which ? bus1.resp_rdata : bus.resp_rdata, 32'h0);
    check({name, " resp_seen"}, which ? q1.size() : q0.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_size = 2'b10; bus.req_signed = 1'b0; bus.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0;
    bus1.req_size = 2'b10; bus1.req_signed = 1'b0; bus1.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset stall", {31'b0, bus.stall}, 32'd0);
    check("reset resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("reset rdata", bus.resp_rdata, 32'h0);
    check("reset err", {31'b0, bus.resp_err}, 32'd0);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    do_req(0, "sw 0x10", 1, 32'h10, 2'b10, 0, 32'h1234_5678, 32'h0, 0);
    do_req(0, "lw 0x10", 0, 32'h10, 2'b10, 0, 32'h0, 32'h1234_5678, 0);
    do_req(0, "sb 0x11", 1, 32'h11, 2'b00, 0, 32'h0000_00AB, 32'h0, 0);
    do_req(0, "lb 0x11", 0, 32'h11, 2'b00, 1, 32'h0, 32'hFFFF_FFAB, 0);
    do_req(0, "lbu 0x11", 0, 32'h11, 2'b00, 0, 32'h0, 32'h0000_00AB, 0);
    do_req(0, "lw 0x10 after sb", 0, 32'h10, 2'b10, 1, 32'h0, 32'h1234_AB78, 0);
    do_req(0, "sw 0x10 again", 1, 32'h10, 2'b10, 0, 32'h1234_5678, 32'h0, 0);
    do_req(0, "sh 0x12", 1, 32'h12, 2'b01, 0, 32'h0000_8001, 32'h0, 0);
    do_req(0, "lh 0x12", 0, 32'h12, 2'b01, 1, 32'h0, 32'hFFFF_8001, 0);
    do_req(0, "lhu 0x12", 0, 32'h12, 2'b01, 0, 32'h0, 32'h0000_8001, 0);
    do_req(0, "lw 0x10 after sh", 0, 32'h10, 2'b10, 0, 32'h0, 32'h8001_5678, 0);
    do_req(0, "sw 0x21 misaligned", 1, 32'h21, 2'b10, 0, 32'hDEAD_BEEF, 32'h0, 1);
    do_req(0, "lh 0x13 misaligned", 0, 32'h13, 2'b01, 1, 32'h0, 32'h0, 1);
    do_req(0, "size11 0x20", 0, 32'h20, 2'b11, 0, 32'h0, 32'h0, 1);
    do_req(0, "lw 0x20", 0, 32'h20, 2'b10, 0, 32'h0, 32'h0, 0);
    do_req(0, "sw 0x1004", 1, 32'h1004, 2'b10, 0, 32'hCAFE_F00D, 32'h0, 0);
    do_req(0, "lw 0x4 wrap", 0, 32'h4, 2'b10, 0, 32'h0, 32'hCAFE_F00D, 0);

    // Reset during the wait cycle abandons the store.
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h30;
    bus.req_size = 2'b10; bus.req_signed = 1'b0; bus.req_wdata = 32'h55;
    @(posedge clk);
    #1;
    check("abort wait stall", {31'b0, bus.stall}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort stall in reset", {31'b0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort no resp", {31'b0, bus.resp_valid}, 32'd0);
    do_req(0, "lw 0x30 after abort", 0, 32'h30, 2'b10, 0, 32'h0, 32'h0, 0);
    do_req(0, "lw 0x4 after reset", 0, 32'h4, 2'b10, 0, 32'h0, 32'h0, 0);

    // LATENCY = 1 instance.
    do_req(1, "L1 sw 0x30", 1, 32'h30, 2'b10, 0, 32'h0000_0055, 32'h0, 0);
    do_req(1, "L1 lw 0x30", 0, 32'h30, 2'b10, 0, 32'h0, 32'h0000_0055, 0);
    do_req(1, "L1 sb 0x33", 1, 32'h33, 2'b00, 0, 32'h0000_0090, 32'h0, 0);
    do_req(1, "L1 lb 0x33", 0, 32'h33, 2'b00, 1, 32'h0, 32'hFFFF_FF90, 0);
    do_req(1, "L1 lw 0x30 merged", 0, 32'h30, 2'b10, 0, 32'h0, 32'h9000_0055, 0);

    check("q0 drained", q0.size(), 32'd0);
    check("q1 drained", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
